// File: rtl/sp_threadgroup_acc_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_threadgroup_acc_if
// Description : Tile control, beat stream and result handshake bundle for
//               the sparse thread-group accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_threadgroup_acc_if #(
    parameter int NUM_WG = 2,
    parameter int NUM_AG = 2,
    parameter int ACC_W  = 16,
    parameter int KLEN_W = 8
);
    localparam int NDP = NUM_WG * NUM_AG;

    logic                    start;
    logic                    cfg_sparse;
    logic [KLEN_W-1:0]       k_len;
    logic [NDP*ACC_W-1:0]    psum_in;
    logic                    busy;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_WG*32-1:0]    weight;
    logic [NUM_WG*8-1:0]     weight_idx;
    logic [NUM_AG*64-1:0]    act;
    logic                    out_valid;
    logic                    out_ready;
    logic [NDP*ACC_W-1:0]    result;
    logic [NDP-1:0]          sat_flag;

    modport master (
        output start, cfg_sparse, k_len, psum_in,
        output in_valid, weight, weight_idx, act,
        output out_ready,
        input  busy, in_ready, out_valid, result, sat_flag
    );

    modport slave (
        input  start, cfg_sparse, k_len, psum_in,
        input  in_valid, weight, weight_idx, act,
        input  out_ready,
        output busy, in_ready, out_valid, result, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/sp_threadgroup_acc.sv
`default_nettype none
// ============================================================================
// Module      : sp_threadgroup_acc
// Description : Array of 4-lane dot-product units with 2:4 sparse / dense
//               activation select, 2-stage pipeline, saturating K reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_threadgroup_acc #(
    parameter int NUM_WG = 2,
    parameter int NUM_AG = 2,
    parameter int ACC_W  = 16,
    parameter int KLEN_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sp_threadgroup_acc_if.slave bus
);
    localparam int c_NDP   = NUM_WG * NUM_AG;
    localparam int c_SUM_W = 18;
    localparam int c_EXT_W = ((ACC_W > c_SUM_W) ? ACC_W : c_SUM_W) + 1;
    localparam logic signed [c_EXT_W-1:0] c_MAX =
        {{(c_EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [c_EXT_W-1:0] c_MIN =
        {{(c_EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_sparse;
    logic [KLEN_W-1:0]           r_klen;
    logic [KLEN_W-1:0]           r_cnt;
    logic                        r_drain;
    logic                        w_start_ok;
    logic                        w_accept;
    logic                        w_last;

    logic [2:0]                  w_lane    [NUM_WG][4];
    logic signed [15:0]          w_prod    [c_NDP][4];
    logic signed [15:0]          r_prod    [c_NDP][4];
    logic                        r_s1_valid;
    logic signed [c_SUM_W-1:0]   w_sum     [c_NDP];
    logic signed [c_EXT_W-1:0]   w_acc_ext [c_NDP];
    logic signed [ACC_W-1:0]     w_acc_nxt [c_NDP];
    logic                        w_clamp   [c_NDP];
    logic signed [ACC_W-1:0]     r_acc     [c_NDP];
    logic [c_NDP-1:0]            r_sat;

    function automatic logic signed [15:0] f_mul(input logic signed [7:0] a,
                                                 input logic signed [7:0] b);
        logic signed [15:0] ax;
        logic signed [15:0] bx;
        ax = 16'(a);
        bx = 16'(b);
        return ax * bx;
    endfunction

    assign w_start_ok = (r_state == ST_IDLE) && bus.start;
    assign w_accept   = (r_state == ST_RUN) && bus.in_valid;
    assign w_last     = w_accept && (r_cnt == (r_klen - 1'b1));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.k_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_drain marks the second DRAIN cycle, by which time stage 2 has retired
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sparse <= 1'b0;
            r_klen   <= '0;
            r_cnt    <= '0;
            r_drain  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_sparse <= bus.cfg_sparse;
                r_klen   <= bus.k_len;
                r_cnt    <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: activation select and products
    // ------------------------------------------------------------------
    // Sparse weights 0-1 index lanes 0-3 and weights 2-3 index lanes 4-7.
    always_comb begin
        for (int w = 0; w < NUM_WG; w++) begin
            for (int j = 0; j < 4; j++) begin
                w_lane[w][j] = r_sparse ? {(j >= 2), bus.weight_idx[w*8 + 2*j +: 2]}
                                        : 3'(j);
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WG; w++) begin
            for (int a = 0; a < NUM_AG; a++) begin
                for (int j = 0; j < 4; j++) begin
                    w_prod[w*NUM_AG + a][j] =
                        f_mul(bus.weight[w*32 + 8*j +: 8],
                              bus.act[a*64 + 8*int'(w_lane[w][j]) +: 8]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_prod <= w_prod;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: reduce and saturating accumulate
    // ------------------------------------------------------------------
    always_comb begin
        for (int d = 0; d < c_NDP; d++) begin
            w_sum[d] = c_SUM_W'(r_prod[d][0]) + c_SUM_W'(r_prod[d][1])
                     + c_SUM_W'(r_prod[d][2]) + c_SUM_W'(r_prod[d][3]);
            w_acc_ext[d] = c_EXT_W'(r_acc[d]) + c_EXT_W'(w_sum[d]);
            w_clamp[d]   = 1'b0;
            if (w_acc_ext[d] > c_MAX) begin
                w_acc_nxt[d] = c_MAX[ACC_W-1:0];
                w_clamp[d]   = 1'b1;
            end else if (w_acc_ext[d] < c_MIN) begin
                w_acc_nxt[d] = c_MIN[ACC_W-1:0];
                w_clamp[d]   = 1'b1;
            end else begin
                w_acc_nxt[d] = w_acc_ext[d][ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < c_NDP; d++) begin
                r_acc[d] <= '0;
            end
            r_sat <= '0;
        end else if (w_start_ok) begin
            for (int d = 0; d < c_NDP; d++) begin
                r_acc[d] <= bus.psum_in[d*ACC_W +: ACC_W];
            end
            r_sat <= '0;
        end else if (r_s1_valid) begin
            for (int d = 0; d < c_NDP; d++) begin
                r_acc[d] <= w_acc_nxt[d];
                r_sat[d] <= r_sat[d] | w_clamp[d];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.in_ready  = (r_state == ST_RUN);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.sat_flag  = r_sat;

    generate
        for (genvar d = 0; d < c_NDP; d++) begin : g_result
            assign bus.result[d*ACC_W +: ACC_W] = r_acc[d];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_sp_threadgroup_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_threadgroup_acc
// Description : Directed self-checking bench for sp_threadgroup_acc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_threadgroup_acc;
    localparam int NUM_WG = 2;
    localparam int NUM_AG = 2;
    localparam int ACC_W  = 16;
    localparam int KLEN_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    sp_threadgroup_acc_if #(.NUM_WG(NUM_WG), .NUM_AG(NUM_AG), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) bus ();

    sp_threadgroup_acc #(.NUM_WG(NUM_WG), .NUM_AG(NUM_AG), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] res(input int d);
        return bus.result[d*ACC_W +: ACC_W];
    endfunction

    task automatic start_tile(input logic sparse, input logic [7:0] klen,
                              input logic [63:0] psum);
        bus.start      = 1'b1;
        bus.cfg_sparse = sparse;
        bus.k_len      = klen;
        bus.psum_in    = psum;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    task automatic feed(input logic [31:0] pat, input int ncyc, input int start_at,
                        output int n_acc);
        logic hs;
        n_acc = 0;
        for (int i = 0; i < ncyc; i++) begin
            bus.in_valid = pat[i];
            bus.start    = (i == start_at);
            hs = bus.in_valid & bus.in_ready;
            @(posedge clk); #1;
            if (hs) n_acc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    // Latency counted in cycles from the cycle the last beat was presented
    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 0, 1);
        lat = n + 1;
    endtask

    task automatic ack(input logic also_start);
        bus.out_ready = 1'b1;
        bus.start     = also_start;
        bus.k_len     = '0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("ack_idle", bus.busy, 0);
    endtask

    initial begin
        int lat;
        int nacc;
        logic signed [15:0] held;
        logic stable;

        bus.start = 0; bus.cfg_sparse = 0; bus.k_len = 0; bus.psum_in = 0;
        bus.in_valid = 0; bus.weight = 0; bus.weight_idx = 0; bus.act = 0;
        bus.out_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_sat", bus.sat_flag, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Dense single beat with seed 10: 10 + 1+2+3+4
        bus.weight = {32'h0, 32'h04030201};
        bus.act    = {64'h0, 64'h0000_0000_0101_0101};
        start_tile(1'b0, 8'd1, {48'h0, 16'd10});
        feed(32'h1, 1, -1, nacc);
        wait_done(lat);
        check("t1_latency", lat, 3);
        check("t1_res0", res(0), 20);
        check("t1_sat", bus.sat_flag, 0);
        ack(1'b0);

        // Saturation positive: 4*127*127 = 64516
        bus.weight = {8{8'h7F}};
        bus.act    = {16{8'h7F}};
        start_tile(1'b0, 8'd1, 64'h0);
        feed(32'h1, 1, -1, nacc);
        wait_done(lat);
        check("satp_res0", res(0), 32767);
        check("satp_res3", res(3), 32767);
        check("satp_flag", bus.sat_flag, 4'hF);
        ack(1'b0);

        // Saturation negative: 4*-128*127 = -65024
        bus.weight = {8{8'h80}};
        start_tile(1'b0, 8'd1, 64'h0);
        feed(32'h1, 1, -1, nacc);
        wait_done(lat);
        check("satn_res0", res(0), -32768);
        check("satn_flag", bus.sat_flag, 4'hF);
        ack(1'b0);

        // Sparse: lanes 1,2,4,7 -> 14; flag cleared after saturated tile
        bus.weight     = {8{8'h01}};
        bus.weight_idx = {8'h00, 8'b11_00_10_01};
        bus.act        = {2{64'h0706_0504_0302_0100}};
        start_tile(1'b1, 8'd1, 64'h0);
        feed(32'h1, 1, -1, nacc);
        wait_done(lat);
        check("sparse_res0", res(0), 14);
        check("sparse_res1", res(1), 14);
        check("sparse_sat_clr", bus.sat_flag, 0);
        ack(1'b0);

        // Same data dense: lanes 0..3 -> 6
        start_tile(1'b0, 8'd1, 64'h0);
        feed(32'h1, 1, -1, nacc);
        wait_done(lat);
        check("dense_res0", res(0), 6);
        ack(1'b0);

        // Backpressure k=3, valid 1,0,1,0,0,1, stray start while running
        bus.weight     = {8{8'h01}};
        bus.weight_idx = '0;
        bus.act        = {16{8'h02}};
        start_tile(1'b0, 8'd3, 64'h0);
        bus.psum_in = {4{16'h1234}};
        feed(32'b100101, 6, 1, nacc);
        bus.psum_in = '0;
        check("bp_beats", nacc, 3);
        check("bp_ready_after_last", bus.in_ready, 0);
        wait_done(lat);
        check("bp_latency", lat, 3);
        for (int d = 0; d < 4; d++) check($sformatf("bp_res%0d", d), res(d), 24);

        // Hold DONE with out_ready low
        held   = res(2);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (res(2) !== held || !bus.out_valid || bus.in_ready) stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        ack(1'b0);

        // Back-to-back k_len=0: seed returned one cycle after start
        start_tile(1'b0, 8'd0, {16'hFFFB, 48'h0});
        check("k0_out_valid", bus.out_valid, 1);
        check("k0_res3", res(3), -5);
        ack(1'b1);
        check("ack_start_ignored", bus.out_valid, 0);

        // Reset in RUN abandons the tile
        start_tile(1'b0, 8'd3, {4{16'h0007}});
        feed(32'h1, 1, -1, nacc);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_busy", bus.busy, 0);
        check("mrst_in_ready", bus.in_ready, 0);
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_result", bus.result, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mrst_no_out_valid", bus.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sp_threadgroup_acc.md
# sp_threadgroup_acc

Parametrised, pipelined successor of the sparse thread group. It holds an array of four-lane fused dot-product units (DPs), each of which multiplies one compressed weight group against one activation group. Activations are selected per 2:4 structured-sparsity indices, or taken directly in dense mode. The block accumulates a K-deep reduction over a valid/ready beat stream, seeded from an input partial sum, and returns saturated results through an output handshake. It sits between the operand-staging buffers and the tensor-core result collector.

## Interface
- NUM_WG, 2, number of weight groups (4 × 8-bit weights each)
- NUM_AG, 2, number of activation groups (8 × 8-bit activations each)
- ACC_W, 16, signed accumulator/result width per DP (≥18 not required; saturating)
- KLEN_W, 8, width of the beat-count field
- Derived: NDP = NUM_WG*NUM_AG; DP d = w*NUM_AG + a (weight group w × activation group a)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  tile start pulse; honoured only in IDLE
- cfg_sparse  in  1  1 = 2:4 sparse indexing, 0 = dense; sampled on start
- k_len  in  KLEN_W  beats in tile; sampled on start
- psum_in  in  NDP*ACC_W  signed seed per DP; sampled on start
- busy  out  1  high whenever state ≠ IDLE
- in_valid  in  1  beat valid
- in_ready  out  1  high in RUN only
- weight  in  NUM_WG*32  byte j of group w = signed weight j
- weight_idx  in  NUM_WG*8  bits [2j+1:2j] of group w = index of weight j
- act  in  NUM_AG*64  byte i of group a = signed activation i
- out_valid  out  1  results valid
- out_ready  in  1  results consumed
- result  out  NDP*ACC_W  signed accumulated result per DP
- sat_flag  out  NDP  sticky per DP: saturation occurred in this tile

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE + start: latch cfg_sparse and k_len, acc[d] ← psum_in[d], clear sat_flag and the beat counter.
  - k_len = 0 → DONE.
  - Otherwise → RUN.
- RUN: a beat is accepted when in_valid & in_ready. On the last (k_len-th) accepted beat → DRAIN.
- DRAIN: lasts 2 cycles while the pipeline empties, then → DONE.
- DONE: out_valid = 1; result and sat_flag are held stable. out_valid & out_ready → IDLE.
- Start asserted outside IDLE is ignored, including in the cycle of the output handshake.
- Activation selection for weight j of group w against group a:
  - Sparse: act byte 4*(j/2) + idx_j, so weights 0–1 cover lanes 0–3 and weights 2–3 cover lanes 4–7.
  - Dense: act byte j; idx ignored; lanes 4–7 unused.
- Arithmetic:
  - 8×8 signed products, 16 bits each.
  - 4-product sum, 18 bits signed.
  - Accumulate: acc[d] ← sat(acc[d] + sum). Saturation limits are +2^(ACC_W-1)-1 and -2^(ACC_W-1).
  - Any clamp sets sat_flag[d].
  - No wrap-around, ever.
- Pipeline:
  - Stage 1: register the 4 selected products per DP, with a stage-valid bit.
  - Stage 2: sum and accumulate.
- result is the acc register, driven directly.

## Timing
- Reset: state IDLE; busy, in_ready, out_valid = 0; result, sat_flag, acc, pipeline valids = 0.
- Reset mid-operation wins over everything: the tile is abandoned and no out_valid is produced.
- Beat accepted at edge t:
  - Products are registered at t.
  - acc is updated at t+1.
  - out_valid is high from the edge after t+1. If the beat was the last, out_valid is first seen in the cycle after edge t+2.
- Latency, last accepted beat → out_valid: 3 cycles.
- k_len = 0: out_valid 1 cycle after start, with result = psum_in.
- Throughput: 1 beat/cycle in RUN. Gaps in in_valid are allowed; no beat is lost or duplicated.
- out_ready held low: DONE persists indefinitely with result stable; in_ready stays 0.
- Back-to-back tiles: start is accepted in the cycle after the output handshake (IDLE). Minimum tile-to-tile gap is 1 idle cycle.

## Test plan
- Dense, default params, k_len=1, psum_in[0]=10.
  - Stimulus: group-0 weights {1,2,3,4}, act group 0 lanes 0–3 = 1.
  - Required: result[0]=20, out_valid 3 cycles after accept, sat_flag=0.
- Sparse, k_len=1, psum=0.
  - Stimulus: weight_idx group 0 = 8'b11_00_10_01, weights all 1, act lane i = i.
  - Required: result[0] = 1+2+4+7 = 14.
  - Same data with cfg_sparse=0 → result[0] = 0+1+2+3 = 6.
- Backpressure, k_len=3, dense.
  - Stimulus: weights all 1, acts all 2, in_valid pattern 1,0,1,0,0,1.
  - Required: result = 3*8 = 24 per DP; exactly 3 beats consumed; out_valid 3 cycles after the third accept.
- Saturation, ACC_W=16.
  - Stimulus: weights 127, acts 127, k_len=1.
  - Required: result = 32767, sat_flag=1.
  - With weights -128: result = -32768, sat_flag=1.
  - Following unsaturated tile: sat_flag = 0.
- Boundary/control:
  - k_len=0, psum_in[3] = -5 → result[3] = -5 one cycle after start.
  - Start during RUN is ignored.
  - out_ready low for 10 cycles → result stable.
  - rst asserted in RUN → next cycle busy=0, in_ready=0, out_valid=0, result=0.
